// File: rtl/spi_slave_shifter.sv
// SPI mode-0 target endpoint, MSB first: synchronizes SCLK/CS_N/MOSI into the clkin domain,
// assembles received words and shifts MISO out of a one-entry transmit holding buffer.
module spi_slave_shifter #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clkin,
  input  logic              i_reset,
  input  logic              i_sclk,
  input  logic              i_cs_n,
  input  logic              i_mosi,
  output logic              o_miso,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_tx_underrun,
  output logic              o_busy
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sclk_d, r_cs_d;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_reload;
  logic [DATA_W-2:0]      r_rx_shift;
  logic [DATA_W-1:0]      r_tx_shift;
  logic [DATA_W-1:0]      r_buf;
  logic                   r_buf_full;
  logic [DATA_W-1:0]      r_rx_data;
  logic                   r_rx_valid, r_tx_underrun, r_miso;

  logic w_sclk_s, w_cs_s, w_mosi_s;
  logic w_rise, w_fall, w_cs_fall, w_cs_rise;
  logic w_load, w_tx_wr;
  logic [DATA_W-1:0] w_load_word, w_rx_next;

  assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise    = w_sclk_s & ~r_sclk_d;
  assign w_fall    = ~w_sclk_s & r_sclk_d;
  assign w_cs_fall = ~w_cs_s & r_cs_d;
  assign w_cs_rise = w_cs_s & ~r_cs_d;

  // A load empties the buffer; an empty buffer loads zero and flags an underrun.
  assign w_load      = ((r_state == S_IDLE) && w_cs_fall) ||
                       ((r_state == S_ACTIVE) && !w_cs_rise && w_fall && r_reload);
  assign w_load_word = r_buf_full ? r_buf : '0;
  assign w_tx_wr     = i_tx_valid & ~r_buf_full;
  assign w_rx_next   = {r_rx_shift, w_mosi_s};

  always_ff @(posedge i_clkin) begin
    if (i_reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
    end
  end

  // Holding buffer: a write in the same cycle as a load can only happen when it was empty.
  always_ff @(posedge i_clkin) begin
    if (i_reset) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
    end else begin
      if (w_tx_wr) r_buf <= i_tx_data;
      r_buf_full <= w_tx_wr | (r_buf_full & ~w_load);
    end
  end

  always_ff @(posedge i_clkin) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_bit_cnt     <= '0;
      r_reload      <= 1'b0;
      r_rx_shift    <= '0;
      r_tx_shift    <= '0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_miso        <= 1'b0;
    end else begin
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= w_load & ~r_buf_full;
      case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            r_state    <= S_ACTIVE;
            r_bit_cnt  <= '0;
            r_reload   <= 1'b0;
            r_tx_shift <= w_load_word;
            r_miso     <= w_load_word[DATA_W-1];
          end
        end
        S_ACTIVE: begin
          // Deselect outranks any SCLK edge seen in the same cycle.
          if (w_cs_rise) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_reload  <= 1'b0;
            r_miso    <= 1'b0;
          end else if (w_rise) begin
            r_rx_shift <= w_rx_next[DATA_W-2:0];
            if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
              r_rx_data  <= w_rx_next;
              r_rx_valid <= 1'b1;
              r_bit_cnt  <= '0;
              r_reload   <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else if (w_fall) begin
            if (r_reload) begin
              r_tx_shift <= w_load_word;
              r_miso     <= w_load_word[DATA_W-1];
              r_reload   <= 1'b0;
            end else begin
              r_tx_shift <= r_tx_shift << 1;
              r_miso     <= r_tx_shift[DATA_W-2];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_miso        = r_miso;
  assign o_tx_ready    = ~r_buf_full;
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_tx_underrun = r_tx_underrun;
  assign o_busy        = (r_state == S_ACTIVE);

endmodule
